// File: rtl/run_ctrl_pkg.sv
// Shared types for the run/step controller: FSM state encoding and counter limit.
package run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2,
    ST_HALT = 2'd3
  } run_state_e;

  localparam logic [31:0] RUN_CYCLES_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-sample counter and a
// registered single-cycle pulse on each accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int              CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic          level, level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      pulse   <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      pulse   <= level & ~level_d;
      // Any sample that agrees with the current level restarts the run.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer for the MIPS core: debounced go/step buttons drive an
// IDLE/RUN/STEP/HALT FSM. Define RUN_CTRL_BP_EN to enable the PC breakpoint.
module cpu_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int ADDR_W          = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go_btn,
  input  logic              step_btn,
  input  logic              cpu_halted,
  input  logic [ADDR_W-1:0] rom_addr,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic              bp_valid,
  output logic              cpu_ce,
  output logic              cpu_go,
  output logic [1:0]        state,
  output logic [31:0]       run_cycles
);

  run_state_e st, st_n;
  logic       resume, resume_n;
  logic       go_p, step_p;
  logic       bp_hit;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_go_db (
    .clk(clk), .rst(rst), .btn(go_btn), .pulse(go_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk(clk), .rst(rst), .btn(step_btn), .pulse(step_p)
  );

`ifdef RUN_CTRL_BP_EN
  // resume masks the compare for the first cycle so we can leave the stop PC.
  assign bp_hit = bp_valid && (rom_addr == bp_addr) && (st == ST_RUN) && !resume;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_addr, bp_valid};
  assign bp_hit    = 1'b0;
`endif

  assign cpu_ce = ((st == ST_RUN) && !bp_hit) || (st == ST_STEP);
  assign cpu_go = resume;
  assign state  = st;

  always_comb begin
    st_n     = st;
    resume_n = 1'b0;
    case (st)
      ST_IDLE, ST_HALT: begin
        if (go_p)        st_n = ST_RUN;
        else if (step_p) st_n = ST_STEP;
      end
      ST_RUN:  if (cpu_halted || bp_hit) st_n = ST_HALT;
      ST_STEP: st_n = ST_HALT;
      default: st_n = ST_IDLE;
    endcase
    if (((st == ST_IDLE) || (st == ST_HALT)) &&
        ((st_n == ST_RUN) || (st_n == ST_STEP)))
      resume_n = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st         <= ST_IDLE;
      resume     <= 1'b0;
      run_cycles <= '0;
    end else begin
      st     <= st_n;
      resume <= resume_n;
      if (cpu_ce && (run_cycles != RUN_CYCLES_MAX))
        run_cycles <= run_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed sequences, a vector table and a randomized
// run against a window-based behavioural model.
`timescale 1ns/1ps
module tb_cpu_run_ctrl;
  import run_ctrl_pkg::*;

  localparam int D  = 4;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          go_btn = 1'b0, step_btn = 1'b0, cpu_halted = 1'b0, bp_valid = 1'b0;
  logic [AW-1:0] rom_addr = '0, bp_addr = '0;
  logic          cpu_ce, cpu_go;
  logic [1:0]    state;
  logic [31:0]   run_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  cpu_run_ctrl #(.DEBOUNCE_CYCLES(D), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .go_btn(go_btn), .step_btn(step_btn),
    .cpu_halted(cpu_halted), .rom_addr(rom_addr), .bp_addr(bp_addr),
    .bp_valid(bp_valid), .cpu_ce(cpu_ce), .cpu_go(cpu_go),
    .state(state), .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Core stand-in: PC advances across an edge where cpu_ce was high.
  task automatic tick_pc();
    logic adv;
    adv = cpu_ce;
    @(posedge clk);
    @(negedge clk);
    if (adv) rom_addr = rom_addr + 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] s, input int max, input string name);
    int i;
    i = 0;
    while (state !== s && i < max) begin
      if (i == 10) begin go_btn = 1'b0; step_btn = 1'b0; end
      tick_pc();
      i++;
    end
    chk(name, 32'(state), 32'(s));
  endtask

  // ---------------- behavioural model ----------------
  logic [D+1:0] rh_go, rh_st;   // raw button history, bit 0 newest
  logic         lv_go, lv_st;
  logic [1:0]   rd_go, rd_st;   // accepted-rise events delayed to the FSM
  run_state_e   m_st;
  int           m_age;          // cycles spent in current state
  logic [31:0]  m_cnt;

  task automatic m_reset();
    rh_go = '0; rh_st = '0; lv_go = 1'b0; lv_st = 1'b0;
    rd_go = '0; rd_st = '0; m_st = ST_IDLE; m_age = 0; m_cnt = '0;
  endtask

  task automatic m_eval(output logic ce, output logic go, output logic hit);
    logic res;
    res = ((m_st == ST_RUN) || (m_st == ST_STEP)) && (m_age == 0);
`ifdef RUN_CTRL_BP_EN
    hit = bp_valid && (rom_addr == bp_addr) && (m_st == ST_RUN) && !res;
`else
    hit = 1'b0;
`endif
    ce = ((m_st == ST_RUN) && !hit) || (m_st == ST_STEP);
    go = res;
  endtask

  task automatic m_debounce(inout logic [D+1:0] rh, inout logic lv, inout logic [1:0] rd,
                            input logic raw);
    logic rose;
    rose = 1'b0;
    rh = {rh[D:0], raw};
    if (rh[D+1:2] == {D{~lv}}) begin
      rose = ~lv;
      lv   = ~lv;
    end
    rd = {rd[0], rose};
  endtask

  task automatic model_edge();
    logic ce, go, hit;
    run_state_e nxt;
    if (!rst) begin
      m_reset();
      return;
    end
    m_eval(ce, go, hit);
    nxt = m_st;
    case (m_st)
      ST_IDLE, ST_HALT: if (rd_go[1]) nxt = ST_RUN; else if (rd_st[1]) nxt = ST_STEP;
      ST_RUN:           if (cpu_halted || hit) nxt = ST_HALT;
      default:          nxt = ST_HALT;
    endcase
    if (ce && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    if (nxt != m_st) m_age = 0;
    else if (m_age < 1000) m_age++;
    m_st = nxt;
    m_debounce(rh_go, lv_go, rd_go, go_btn);
    m_debounce(rh_st, lv_st, rd_st, step_btn);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       go;
    logic       step;
    int         hold;
    int         halt_at;
    logic [1:0] exp_state;
    int         exp_ce;
    int         exp_go;
  } vec_t;

  vec_t        vecs[8];
  int          ce_n, go_n, pc;
  logic [31:0] rc0;
  logic        seen_run, ce5, m_ce, m_go, m_hit;

  initial begin
    vecs[0] = '{1'b1, 1'b0,  3, -1, ST_HALT,  0, 0};  // go glitch rejected
    vecs[1] = '{1'b0, 1'b1, 12, -1, ST_HALT,  1, 1};  // held step -> one step
    vecs[2] = '{1'b0, 1'b1,  4, -1, ST_HALT,  1, 1};  // exactly D samples accepted
    vecs[3] = '{1'b1, 1'b1, 10, 18, ST_HALT, 11, 1};  // go wins over step
    vecs[4] = '{1'b1, 1'b0, 10, -1, ST_RUN,  22, 1};  // free run
    vecs[5] = '{1'b0, 1'b0,  0,  0, ST_HALT,  1, 0};  // syscall stops run
    vecs[6] = '{1'b0, 1'b0,  0,  3, ST_HALT,  0, 0};  // halt ignored in HALT
    vecs[7] = '{1'b0, 1'b1, 12,  8, ST_HALT,  1, 1};  // halt during STEP

    // Reset then idle
    rst = 1'b0;
    tick(); tick();
    chk("rst_state", 32'(state), 32'(ST_IDLE));
    chk("rst_ce", 32'(cpu_ce), 32'd0);
    chk("rst_go", 32'(cpu_go), 32'd0);
    chk("rst_run", run_cycles, 32'd0);
    rst = 1'b1;
    repeat (50) tick();
    chk("idle_state", 32'(state), 32'(ST_IDLE));
    chk("idle_ce", 32'(cpu_ce), 32'd0);
    chk("idle_run", run_cycles, 32'd0);

    // 3-cycle glitch must not start the core
    go_btn = 1'b1;
    repeat (3) tick();
    go_btn = 1'b0;
    repeat (20) tick();
    chk("glitch_idle", 32'(state), 32'(ST_IDLE));

    // Go latency and syscall stop
    go_btn = 1'b1;
    for (int k = 1; k <= 34; k++) begin
      tick();
      if (k == 7) chk("go_lat_pre", 32'(state), 32'(ST_IDLE));
      if (k == 8) begin
        chk("go_lat_run", 32'(state), 32'(ST_RUN));
        chk("go_pulse", 32'(cpu_go), 32'd1);
        chk("go_ce", 32'(cpu_ce), 32'd1);
        chk("run_at_entry", run_cycles, 32'd0);
      end
      if (k == 9) chk("go_pulse_end", 32'(cpu_go), 32'd0);
      if (k == 10) go_btn = 1'b0;
      if (k == 28) cpu_halted = 1'b1;
      if (k == 29) begin
        cpu_halted = 1'b0;
        chk("sys_state", 32'(state), 32'(ST_HALT));
        chk("sys_run", run_cycles, 32'd21);
      end
      if (k == 34) chk("sys_frozen", run_cycles, 32'd21);
    end

    // Table vectors, each over a 30-cycle window
    for (int v = 0; v < 8; v++) begin
      ce_n = 0; go_n = 0; rc0 = run_cycles;
      for (int k = 0; k < 30; k++) begin
        go_btn     = vecs[v].go   && (k < vecs[v].hold);
        step_btn   = vecs[v].step && (k < vecs[v].hold);
        cpu_halted = (k == vecs[v].halt_at);
        #1;
        ce_n += int'(cpu_ce);
        go_n += int'(cpu_go);
        tick();
      end
      cpu_halted = 1'b0;
      chk($sformatf("vec%0d_state", v), 32'(state), 32'(vecs[v].exp_state));
      chk($sformatf("vec%0d_ce_cycles", v), 32'(ce_n), 32'(vecs[v].exp_ce));
      chk($sformatf("vec%0d_go_pulses", v), 32'(go_n), 32'(vecs[v].exp_go));
      chk($sformatf("vec%0d_run_delta", v), run_cycles - rc0, 32'(vecs[v].exp_ce));
    end

    // Breakpoint
    bp_addr = 10'h005; bp_valid = 1'b1; rom_addr = '0;
    go_btn = 1'b1; seen_run = 1'b0; ce5 = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (k == 10) go_btn = 1'b0;
      if (state == ST_RUN) seen_run = 1'b1;
      if (seen_run && state == ST_HALT) break;
      if (state == ST_RUN && rom_addr == 10'd5) ce5 = cpu_ce;
      tick_pc();
    end
    go_btn = 1'b0;
`ifdef RUN_CTRL_BP_EN
    chk("bp_state", 32'(state), 32'(ST_HALT));
    chk("bp_pc", 32'(rom_addr), 32'd5);
    chk("bp_ce_at_hit", 32'(ce5), 32'd0);
    repeat (20) tick();
    go_btn = 1'b1;
    wait_state(ST_RUN, 20, "bp_resume_run");
    go_btn = 1'b0;
    chk("bp_resume_ce", 32'(cpu_ce), 32'd1);
    chk("bp_resume_go", 32'(cpu_go), 32'd1);
    chk("bp_resume_pc", 32'(rom_addr), 32'd5);
    tick_pc();
    chk("bp_past_pc", 32'(rom_addr), 32'd6);
    chk("bp_past_state", 32'(state), 32'(ST_RUN));
`else
    repeat (30) tick_pc();
    chk("nobp_state", 32'(state), 32'(ST_RUN));
    chk("nobp_past", 32'(rom_addr > 10'd5), 32'd1);
`endif
    bp_valid = 1'b0;
    cpu_halted = 1'b1;
    tick();
    cpu_halted = 1'b0;
    chk("bp_stop", 32'(state), 32'(ST_HALT));

    // Coincident buttons then counter saturation
    repeat (20) tick();
    go_btn = 1'b1; step_btn = 1'b1;
    wait_state(ST_RUN, 20, "sat_both_run");
    go_btn = 1'b0; step_btn = 1'b0;
    force dut.run_cycles = 32'hFFFF_FFFC;
    tick();
    release dut.run_cycles;
    repeat (6) tick();
    chk("sat_hold", run_cycles, 32'hFFFF_FFFF);
    tick(); tick();
    chk("sat_stay", run_cycles, 32'hFFFF_FFFF);
    cpu_halted = 1'b1;
    tick();
    cpu_halted = 1'b0;

    // Randomized run against the model
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    m_reset();
    pc = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) go_btn = ~go_btn;
      if ($urandom_range(0, 9) == 0) step_btn = ~step_btn;
      cpu_halted = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) begin
        bp_valid = 1'($urandom_range(0, 1));
        bp_addr  = AW'($urandom_range(0, 11));
      end
      rst = ($urandom_range(0, 599) != 0);
      rom_addr = AW'(pc);
      #1;
      m_eval(m_ce, m_go, m_hit);
      chk($sformatf("rnd%0d_state", c), 32'(state), 32'(m_st));
      chk($sformatf("rnd%0d_ce", c), 32'(cpu_ce), 32'(m_ce));
      chk($sformatf("rnd%0d_go", c), 32'(cpu_go), 32'(m_go));
      chk($sformatf("rnd%0d_run", c), run_cycles, m_cnt);
      @(posedge clk);
      model_edge();
      if (m_ce) pc = (pc + 1) % 12;
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run/step controller that sequences the single-cycle MIPS core from the board buttons. It debounces the `go` and `step` push-buttons and runs a four-state FSM (IDLE/RUN/STEP/HALT). From that FSM it drives the core's clock-enable and `go` inputs, stops on syscall halt or an optional PC breakpoint, and counts enabled cycles for the LED/segment display path. It sits between the board I/O wrapper and the CPU core.

## Interface
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized samples required to accept a button level change; board builds override to about 1_000_000.
- `ADDR_W`, 10: width of the instruction word address compared for breakpoints.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  reset. **Synchronous, active-low**: sampled on `clk` rising edge, asserted when 0.
- `go_btn`  in  1  raw asynchronous go button, active-high.
- `step_btn`  in  1  raw asynchronous single-step button, active-high.
- `cpu_halted`  in  1  core reports syscall halt (syscall with $v0 != 34).
- `rom_addr`  in  ADDR_W  current PC word address from the core.
- `bp_addr`  in  ADDR_W  breakpoint word address.
- `bp_valid`  in  1  breakpoint armed.
- `cpu_ce`  out  1  core clock-enable: PC, register file, RAM write and core counters advance only when high.
- `cpu_go`  out  1  one-cycle release pulse into the core `go` input.
- `state`  out  2  FSM state: IDLE=0, RUN=1, STEP=2, HALT=3.
- `run_cycles`  out  32  count of cycles with `cpu_ce`=1.

## Operation
- **Debounce, per button**
  - 2-flop synchronizer feeds a stable counter.
  - The debounced level changes only after DEBOUNCE_CYCLES consecutive equal samples that differ from the current level.
  - A rising edge of the debounced level produces a single-cycle pulse (`go_p`, `step_p`).
- **FSM transitions**, evaluated every edge:
  - **IDLE**: `go_p` → RUN; else `step_p` → STEP.
  - **RUN**: `cpu_halted` → HALT; else breakpoint hit → HALT; else stay.
  - **STEP**: unconditionally → HALT after exactly one cycle.
  - **HALT**: `go_p` → RUN; else `step_p` → STEP.
  - `go_p` and `step_p` in the same cycle: go wins.
- **Breakpoint hit** = `bp_valid` && `rom_addr`==`bp_addr` && state==RUN && !`resume`.
  - `resume` is a flag set on every entry into RUN or STEP and cleared after one cycle.
  - Its purpose is to let execution continue past the breakpoint that stopped it.
- **`cpu_ce`** = (state==RUN && !bp_hit) || state==STEP (combinational).
  - The instruction at the breakpoint PC is not executed.
  - When `cpu_halted` is seen in RUN, `cpu_ce` stays 1 that cycle; the core gates its own PC on halt.
- **`cpu_go`** = `resume`. It is high in the first RUN/STEP cycle, so the core steps past a pending syscall.
- **`run_cycles`** increments when `cpu_ce`=1 and saturates at 32'hFFFF_FFFF.

## Timing
- **Reset values**: `state`=IDLE, `cpu_ce`=0, `cpu_go`=0, `run_cycles`=0, `resume`=0, debounced levels 0, debounce counters 0.
- **Button latency**: raw rise at edge 0 gives a pulse at edge 2+DEBOUNCE_CYCLES. A bounce shorter than DEBOUNCE_CYCLES produces no pulse.
- **Pulse to execution**: pulse at edge t gives state RUN/STEP and `cpu_ce`=`cpu_go`=1 at cycle t+1.
- **STEP**: exactly one cycle of `cpu_ce`=1, then HALT at t+2.
- **Holding `step_btn`** yields one step only; a release and re-press are required.
- **Reset mid-run**: the next edge with `rst`=0 forces the reset values regardless of state. An in-flight pulse is discarded.
- **`cpu_halted` asserted in IDLE/HALT**: ignored. In STEP it is ignored because HALT follows anyway.

## Configuration
- **`RUN_CTRL_BP_EN` defined**: breakpoint compare and the `resume` qualification exist as described.
- **Not defined**: bp_hit is constant 0. `bp_addr` and `bp_valid` remain ports but are unused. RUN leaves only on `cpu_halted`.

## Structure
- **Package `run_ctrl_pkg`**: state enum (`ST_IDLE`, `ST_RUN`, `ST_STEP`, `ST_HALT`, 2-bit encoding as above) and `RUN_CYCLES_MAX` constant.
- **Sub-module `btn_debounce`**: synchronizer, counter and rising-edge pulse, parameterized by DEBOUNCE_CYCLES. Instantiated twice.

## Test plan
- **Reset then idle**: `rst`=0 for 2 cycles, release, no buttons for 50 cycles → `state`=0, `cpu_ce`=0, `run_cycles`=0.
- **Debounce reject/accept**: `go_btn` glitch of 3 cycles → no transition. Then held 10 cycles → RUN exactly 7 cycles after rise, `cpu_go`=1 for one cycle.
- **Syscall stop**: in RUN, assert `cpu_halted` at cycle 20 after entry → `state`=3 next cycle. `run_cycles`=21 and stays frozen.
- **Single step**: from HALT, press `step_btn` twice → two single-cycle `cpu_ce` pulses, `run_cycles` increases by exactly 2.
- **Breakpoint** (`RUN_CTRL_BP_EN`): `bp_addr`=10'h005, `bp_valid`=1, `rom_addr` increments from 0 while `cpu_ce`=1 → HALT with `cpu_ce`=0 at `rom_addr`=5. Press go → `cpu_ce`=1 at `rom_addr`=5, continues to 6.
- **Simultaneous buttons and saturation**: `go_p`/`step_p` coincident in HALT → RUN. Force `run_cycles` near 32'hFFFF_FFFE and run 5 cycles → holds 32'hFFFF_FFFF.
